roberto_rx_medidas: RTL



---
 rtl/roberto_rx_medidas_pkg.sv | 17 +
 rtl/rx_serial_7E1.sv | 74 +++++++
 rtl/roberto_rx_medidas.sv | 103 ++++++++++
 3 files changed

// File: rtl/roberto_rx_medidas_pkg.sv
// roberto_rx_medidas_pkg: ASCII constants, frame length and state encodings shared by the receiver
package roberto_rx_medidas_pkg;

   localparam logic [6:0] ASCII_0         = 7'h30;
   localparam logic [6:0] ASCII_9         = 7'h39;
   localparam logic [6:0] ASCII_VIRGULA   = 7'h2C;
   localparam logic [6:0] ASCII_CERQUILHA = 7'h23;
   localparam int         FRAME_LEN       = 12;

   typedef enum logic [2:0] {OCIOSO, INICIO, DADOS, PARIDADE, PARADA} uart_estado_t;
   typedef enum logic [3:0] {RECEBE = 4'h1, RESINCRONIZA = 4'hE} parser_estado_t;

   function automatic logic eh_digito(input logic [6:0] c);
      return (c >= ASCII_0) && (c <= ASCII_9);
   endfunction

endpackage

// File: rtl/rx_serial_7E1.sv
// rx_serial_7E1: 7E1 UART receiver with input synchroniser, mid-bit sampling and parity/stop checking
module rx_serial_7E1
   import roberto_rx_medidas_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_rx,
   output logic [6:0] o_dado,
   output logic       o_char_ok,
   output logic       o_char_err
);

   localparam int             W        = $clog2(CLKS_PER_BIT);
   localparam logic [W-1:0]   FIM_BIT  = W'(CLKS_PER_BIT - 1);
   localparam logic [W-1:0]   FIM_MEIO = W'(CLKS_PER_BIT / 2 - 1);

   uart_estado_t r_estado, w_prox;
   logic         r_rx_meta, r_rx_sync, r_rx_ant, r_par;
   logic [W-1:0] r_cnt;
   logic [2:0]   r_nbit;
   logic [6:0]   r_dado;
   logic         w_queda, w_meio, w_bit, w_amostra;

   assign w_queda    = r_rx_ant & ~r_rx_sync;
   assign w_meio     = (r_estado == INICIO) && (r_cnt == FIM_MEIO);
   assign w_bit      = (r_estado == DADOS || r_estado == PARIDADE || r_estado == PARADA) && (r_cnt == FIM_BIT);
   assign w_amostra  = w_meio | w_bit;
   assign o_char_ok  = (r_estado == PARADA) && w_bit && r_rx_sync && (r_par == ^r_dado);
   assign o_char_err = (r_estado == PARADA) && w_bit && !o_char_ok;
   assign o_dado     = r_dado;

   // two-flop synchroniser plus one delayed copy for falling-edge detection, all idle high
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) {r_rx_meta, r_rx_sync, r_rx_ant} <= 3'b111;
      else {r_rx_meta, r_rx_sync, r_rx_ant} <= {i_rx, r_rx_meta, r_rx_sync};

   // UART state register
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) r_estado <= OCIOSO;
      else r_estado <= w_prox;

   // next state: a high half-bit sample means the start edge was a glitch
   always_comb begin
      w_prox = r_estado;
      case (r_estado)
         OCIOSO:   if (w_queda) w_prox = INICIO;
         INICIO:   if (w_meio) w_prox = r_rx_sync ? OCIOSO : DADOS;
         DADOS:    if (w_bit && r_nbit == 3'd6) w_prox = PARIDADE;
         PARIDADE: if (w_bit) w_prox = PARADA;
         PARADA:   if (w_bit) w_prox = OCIOSO;
         default:  w_prox = OCIOSO;
      endcase
   end

   // bit timer restarts at every sample; data shifts in LSB first
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) begin
         r_cnt  <= '0;
         r_nbit <= '0;
         r_dado <= '0;
         r_par  <= 1'b0;
      end else begin
         r_cnt <= (r_estado == OCIOSO || w_amostra) ? '0 : r_cnt + 1'b1;
         if (w_meio) r_nbit <= '0;
         if (w_bit && r_estado == DADOS) begin
            r_dado <= {r_rx_sync, r_dado[6:1]};
            r_nbit <= r_nbit + 3'd1;
         end
         if (w_bit && r_estado == PARIDADE) r_par <= r_rx_sync;
      end

endmodule

// File: rtl/roberto_rx_medidas.sv
// roberto_rx_medidas: parses "DDD,DDD,DDD#" frames from the UART and publishes three BCD distances atomically
module roberto_rx_medidas
   import roberto_rx_medidas_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        RX,
   output logic [11:0] medida1,
   output logic [11:0] medida2,
   output logic [11:0] medida3,
   output logic        pronto,
   output logic        erro,
   output logic [3:0]  db_estado,
   output logic [3:0]  db_indice
);

   logic [6:0]     w_dado;
   logic           w_ok, w_err, w_ev, w_cerq, w_valido, w_grava;
   parser_estado_t r_estado, w_estado_n;
   logic [3:0]     r_idx, w_idx_n;
   logic           r_pronto, r_erro, w_pronto_n, w_erro_n;
   logic [3:0]     r_sombra [FRAME_LEN];
   logic [11:0]    r_medida1, r_medida2, r_medida3;

   rx_serial_7E1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .i_clk      (clock),
      .i_rst      (reset),
      .i_rx       (RX),
      .o_dado     (w_dado),
      .o_char_ok  (w_ok),
      .o_char_err (w_err)
   );

   assign w_ev     = w_ok | w_err;
   assign w_cerq   = w_ok && (w_dado == ASCII_CERQUILHA);
   assign w_valido = w_ok && ((r_idx == 4'd11) ? (w_dado == ASCII_CERQUILHA) :
                              (r_idx == 4'd3 || r_idx == 4'd7) ? (w_dado == ASCII_VIRGULA) : eh_digito(w_dado));
   assign w_grava  = (r_estado == RECEBE) && w_valido;

   assign medida1   = r_medida1;
   assign medida2   = r_medida2;
   assign medida3   = r_medida3;
   assign pronto    = r_pronto;
   assign erro      = r_erro;
   assign db_estado = r_estado;
   assign db_indice = r_idx;

   // parser registers
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         r_estado <= RECEBE;
         r_idx    <= '0;
         r_pronto <= 1'b0;
         r_erro   <= 1'b0;
      end else begin
         r_estado <= w_estado_n;
         r_idx    <= w_idx_n;
         r_pronto <= w_pronto_n;
         r_erro   <= w_erro_n;
      end

   // next state: a clean '#' at a wrong index counts as its own resync point
   always_comb begin
      w_estado_n = r_estado;
      w_idx_n    = r_idx;
      w_pronto_n = 1'b0;
      w_erro_n   = 1'b0;
      if (r_estado == RESINCRONIZA) begin
         if (w_cerq) begin
            w_estado_n = RECEBE;
            w_idx_n    = '0;
         end
      end else if (w_valido) begin
         w_pronto_n = (r_idx == 4'd11);
         w_idx_n    = (r_idx == 4'd11) ? 4'd0 : r_idx + 4'd1;
      end else if (w_ev) begin
         w_erro_n   = 1'b1;
         w_idx_n    = '0;
         w_estado_n = w_cerq ? RECEBE : RESINCRONIZA;
      end
   end

   // shadow digits fill per index; outputs load only from a complete frame
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         for (int k = 0; k < FRAME_LEN; k++) r_sombra[k] <= '0;
         r_medida1 <= '0;
         r_medida2 <= '0;
         r_medida3 <= '0;
      end else if (w_grava) begin
         r_sombra[r_idx] <= w_dado[3:0];
         if (r_idx == 4'd11) begin
            r_medida1 <= {r_sombra[0], r_sombra[1], r_sombra[2]};
            r_medida2 <= {r_sombra[4], r_sombra[5], r_sombra[6]};
            r_medida3 <= {r_sombra[8], r_sombra[9], r_sombra[10]};
         end
      end else if (w_erro_n) begin
         for (int k = 0; k < FRAME_LEN; k++) r_sombra[k] <= '0;
      end

endmodule
